// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default datapath widths, ALU op encoding,
// forwarding-source select and the ID/EX stage's implicit control states.
package cpu_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int IDX_W_DEF = 3;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SHL = 3'b110,
        ALU_SHR = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_EXM = 2'd1,
        FWD_MWB = 2'd2
    } fwd_sel_e;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HOLD   = 2'd1,
        ST_BUBBLE = 2'd2
    } stage_state_e;

endpackage

// File: rtl/operand_fwd_mux.sv
// Priority operand select: EX/MEM over MEM/WB over register-file data.
// sel_o always reports the matching source; the value is only bypassed with IDEX_FWD_EN.
module operand_fwd_mux
    import cpu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic             used_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [WIDTH-1:0] reg_val_i,
    input  logic             exm_wr_en_i,
    input  logic [IDX_W-1:0] exm_wr_idx_i,
    input  logic [WIDTH-1:0] exm_result_i,
    input  logic             mwb_wr_en_i,
    input  logic [IDX_W-1:0] mwb_wr_idx_i,
    input  logic [WIDTH-1:0] mwb_result_i,
    output logic [WIDTH-1:0] val_o,
    output fwd_sel_e         sel_o
);

    logic exm_hit, mwb_hit;

    // A writer only matches when it actually writes; index equality alone is not enough.
    assign exm_hit = used_i && exm_wr_en_i && (exm_wr_idx_i == idx_i);
    assign mwb_hit = used_i && mwb_wr_en_i && (mwb_wr_idx_i == idx_i);

    always_comb begin
        sel_o = FWD_REG;
        if (exm_hit)      sel_o = FWD_EXM;
        else if (mwb_hit) sel_o = FWD_MWB;
    end

`ifdef IDEX_FWD_EN
    always_comb begin
        val_o = reg_val_i;
        case (sel_o)
            FWD_EXM: val_o = exm_result_i;
            FWD_MWB: val_o = mwb_result_i;
            default: val_o = reg_val_i;
        endcase
    end
`else
    logic unused_fwd;
    assign val_o      = reg_val_i;
    assign unused_fwd = ^{exm_result_i, mwb_result_i};
`endif

endmodule

// File: rtl/idex_operand_stage.sv
// ID/EX pipeline register with operand selection, load-use / in-flight hazard stall and flush.
// Define IDEX_FWD_EN to bypass EX/MEM and MEM/WB results; otherwise matches stall decode.
module idex_operand_stage
    import cpu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [WIDTH-1:0] id_rs_val,
    input  logic [WIDTH-1:0] id_rt_val,
    input  logic [IDX_W-1:0] id_rs_idx,
    input  logic [IDX_W-1:0] id_rt_idx,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic [WIDTH-1:0] id_imm,
    input  logic             id_use_imm,
    input  logic [2:0]       id_op,
    input  logic             id_inv_a,
    input  logic             id_inv_b,
    input  logic             id_cin,
    input  logic             id_sign,
    input  logic             id_wr_en,
    input  logic [IDX_W-1:0] id_wr_idx,
    input  logic             id_is_load,
    input  logic             exm_wr_en,
    input  logic [IDX_W-1:0] exm_wr_idx,
    input  logic [WIDTH-1:0] exm_result,
    input  logic             mwb_wr_en,
    input  logic [IDX_W-1:0] mwb_wr_idx,
    input  logic [WIDTH-1:0] mwb_result,
    input  logic             stall_in,
    input  logic             flush,
    output logic             ex_valid,
    output logic [WIDTH-1:0] ex_a,
    output logic [WIDTH-1:0] ex_b,
    output logic [2:0]       ex_op,
    output logic             ex_inv_a,
    output logic             ex_inv_b,
    output logic             ex_cin,
    output logic             ex_sign,
    output logic             ex_wr_en,
    output logic [IDX_W-1:0] ex_wr_idx,
    output logic             ex_is_load,
    output logic             id_stall
);

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [2:0]       op;
        logic             inv_a;
        logic             inv_b;
        logic             cin;
        logic             sign;
        logic             wr_en;
        logic [IDX_W-1:0] wr_idx;
        logic             is_load;
    } ex_reg_t;

    ex_reg_t      ex_q, ex_d, cap;
    stage_state_e state;
    logic [WIDTH-1:0] opnd_a, opnd_b;
    fwd_sel_e     sel_a, sel_b;
    logic         used_a, used_b, ex_wr_live, ex_hit_a, ex_hit_b, hazard;

    // B-side sources only matter when the immediate is not selected.
    assign used_a = id_valid && id_rs_used;
    assign used_b = id_valid && id_rt_used && !id_use_imm;

    operand_fwd_mux #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_mux_a (
        .used_i(used_a), .idx_i(id_rs_idx), .reg_val_i(id_rs_val),
        .exm_wr_en_i(exm_wr_en), .exm_wr_idx_i(exm_wr_idx), .exm_result_i(exm_result),
        .mwb_wr_en_i(mwb_wr_en), .mwb_wr_idx_i(mwb_wr_idx), .mwb_result_i(mwb_result),
        .val_o(opnd_a), .sel_o(sel_a)
    );

    operand_fwd_mux #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_mux_b (
        .used_i(used_b), .idx_i(id_rt_idx), .reg_val_i(id_rt_val),
        .exm_wr_en_i(exm_wr_en), .exm_wr_idx_i(exm_wr_idx), .exm_result_i(exm_result),
        .mwb_wr_en_i(mwb_wr_en), .mwb_wr_idx_i(mwb_wr_idx), .mwb_result_i(mwb_result),
        .val_o(opnd_b), .sel_o(sel_b)
    );

    assign ex_wr_live = ex_q.valid && ex_q.wr_en;
    assign ex_hit_a   = used_a && ex_wr_live && (ex_q.wr_idx == id_rs_idx);
    assign ex_hit_b   = used_b && ex_wr_live && (ex_q.wr_idx == id_rt_idx);

`ifdef IDEX_FWD_EN
    logic unused_sel;
    assign unused_sel = ^{sel_a, sel_b};
    assign hazard     = ex_q.is_load && (ex_hit_a || ex_hit_b);
`else
    // Without bypass every in-flight writer of a used source must drain first.
    assign hazard = ex_hit_a || ex_hit_b || (sel_a != FWD_REG) || (sel_b != FWD_REG);
`endif

    always_comb begin
        cap         = '0;
        cap.valid   = id_valid;
        cap.a       = opnd_a;
        cap.b       = id_use_imm ? id_imm : opnd_b;
        cap.op      = id_op;
        cap.inv_a   = id_inv_a;
        cap.inv_b   = id_inv_b;
        cap.cin     = id_cin;
        cap.sign    = id_sign;
        cap.wr_en   = id_valid && id_wr_en;
        cap.wr_idx  = id_wr_idx;
        cap.is_load = id_valid && id_is_load;
    end

    // Control state is purely a function of this cycle's inputs; no cause is remembered.
    always_comb begin
        state = ST_RUN;
        if (flush || (!stall_in && (hazard || !id_valid))) state = ST_BUBBLE;
        else if (stall_in)                                  state = ST_HOLD;
    end

    always_comb begin
        ex_d     = ex_q;
        id_stall = 1'b0;
        case (state)
            ST_RUN:  ex_d = cap;
            ST_HOLD: id_stall = 1'b1;
            ST_BUBBLE: begin
                ex_d.valid   = 1'b0;
                ex_d.wr_en   = 1'b0;
                ex_d.is_load = 1'b0;
                id_stall     = hazard && !flush;
            end
            default: ex_d = ex_q;
        endcase
        if (rst) id_stall = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) ex_q <= '0;
        else     ex_q <= ex_d;
    end

    assign ex_valid   = ex_q.valid;
    assign ex_a       = ex_q.a;
    assign ex_b       = ex_q.b;
    assign ex_op      = ex_q.op;
    assign ex_inv_a   = ex_q.inv_a;
    assign ex_inv_b   = ex_q.inv_b;
    assign ex_cin     = ex_q.cin;
    assign ex_sign    = ex_q.sign;
    assign ex_wr_en   = ex_q.wr_en;
    assign ex_wr_idx  = ex_q.wr_idx;
    assign ex_is_load = ex_q.is_load;

endmodule

// File: tb/tb_idex_operand_stage.sv
// Scoreboard bench for idex_operand_stage: driver pushes hand-computed expectations,
// monitor checks id_stall mid-cycle and the ex_ registers just after the edge.
module tb_idex_operand_stage;

    logic        clk;
    logic        rst, id_valid, id_rs_used, id_rt_used, id_use_imm;
    logic [15:0] id_rs_val, id_rt_val, id_imm, exm_result, mwb_result;
    logic [2:0]  id_rs_idx, id_rt_idx, id_op, id_wr_idx, exm_wr_idx, mwb_wr_idx;
    logic        id_inv_a, id_inv_b, id_cin, id_sign, id_wr_en, id_is_load;
    logic        exm_wr_en, mwb_wr_en, stall_in, flush;
    logic        ex_valid, ex_inv_a, ex_inv_b, ex_cin, ex_sign, ex_wr_en, ex_is_load, id_stall;
    logic [15:0] ex_a, ex_b;
    logic [2:0]  ex_op, ex_wr_idx;

    idex_operand_stage #(.WIDTH(16), .IDX_W(3)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs_val(id_rs_val), .id_rt_val(id_rt_val),
        .id_rs_idx(id_rs_idx), .id_rt_idx(id_rt_idx),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_imm(id_imm), .id_use_imm(id_use_imm), .id_op(id_op),
        .id_inv_a(id_inv_a), .id_inv_b(id_inv_b), .id_cin(id_cin), .id_sign(id_sign),
        .id_wr_en(id_wr_en), .id_wr_idx(id_wr_idx), .id_is_load(id_is_load),
        .exm_wr_en(exm_wr_en), .exm_wr_idx(exm_wr_idx), .exm_result(exm_result),
        .mwb_wr_en(mwb_wr_en), .mwb_wr_idx(mwb_wr_idx), .mwb_result(mwb_result),
        .stall_in(stall_in), .flush(flush),
        .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_op(ex_op),
        .ex_inv_a(ex_inv_a), .ex_inv_b(ex_inv_b), .ex_cin(ex_cin), .ex_sign(ex_sign),
        .ex_wr_en(ex_wr_en), .ex_wr_idx(ex_wr_idx), .ex_is_load(ex_is_load),
        .id_stall(id_stall)
    );

    typedef struct {
        string       nm;
        logic        stall, v, we, ld, cd;
        logic [15:0] a, b;
        logic [2:0]  op;
        logic [3:0]  flg;   // {inv_a, inv_b, cin, sign}
        logic [2:0]  widx;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input string f, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s got=%h exp=%h", nm, f, act, exp);
        end
    endtask

    task automatic idle();
        rst = 0; flush = 0; stall_in = 0;
        id_valid = 0; id_rs_val = 0; id_rt_val = 0; id_rs_idx = 0; id_rt_idx = 0;
        id_rs_used = 0; id_rt_used = 0; id_imm = 0; id_use_imm = 0; id_op = 0;
        id_inv_a = 0; id_inv_b = 0; id_cin = 0; id_sign = 0;
        id_wr_en = 0; id_wr_idx = 0; id_is_load = 0;
        exm_wr_en = 0; exm_wr_idx = 0; exm_result = 0;
        mwb_wr_en = 0; mwb_wr_idx = 0; mwb_result = 0;
    endtask

    // Push the expectation for the coming edge, then advance to just after it.
    task automatic issue(input string nm, input logic st, input logic v, input logic we,
                         input logic ld, input logic cd, input logic [15:0] a,
                         input logic [15:0] b, input logic [2:0] op,
                         input logic [3:0] flg, input logic [2:0] widx);
        exp_t e;
        e.nm = nm; e.stall = st; e.v = v; e.we = we; e.ld = ld; e.cd = cd;
        e.a = a; e.b = b; e.op = op; e.flg = flg; e.widx = widx;
        sb.push_back(e);
        @(posedge clk); #2;
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb[0];
                chk(e.nm, "id_stall", 16'(id_stall), 16'(e.stall));
                @(posedge clk); #1;
                chk(e.nm, "ex_valid", 16'(ex_valid), 16'(e.v));
                chk(e.nm, "ex_wr_en", 16'(ex_wr_en), 16'(e.we));
                chk(e.nm, "ex_is_load", 16'(ex_is_load), 16'(e.ld));
                if (e.cd) begin
                    chk(e.nm, "ex_a", ex_a, e.a);
                    chk(e.nm, "ex_b", ex_b, e.b);
                    chk(e.nm, "ex_op", 16'(ex_op), 16'(e.op));
                    chk(e.nm, "ex_flags", 16'({ex_inv_a, ex_inv_b, ex_cin, ex_sign}), 16'(e.flg));
                    chk(e.nm, "ex_wr_idx", 16'(ex_wr_idx), 16'(e.widx));
                end
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic dec_rs3();
        idle();
        id_valid = 1; id_rs_idx = 3; id_rs_used = 1; id_rs_val = 16'h0001;
        id_rt_idx = 0; id_rt_val = 16'h5555; id_op = 3'd1; id_wr_en = 1; id_wr_idx = 6;
    endtask

    task automatic dec_use_r5();
        idle();
        id_valid = 1; id_rs_idx = 1; id_rs_used = 1; id_rs_val = 16'h0010;
        id_rt_idx = 5; id_rt_used = 1; id_rt_val = 16'h0BAD; id_wr_en = 1; id_wr_idx = 3;
    endtask

    initial begin
        idle(); rst = 1;
        @(posedge clk); #2;

        // reset wins over stall_in and a valid decode
        idle(); rst = 1; id_valid = 1; stall_in = 1; id_rs_val = 16'h1234;
        id_wr_en = 1; id_is_load = 1; id_op = 3'd7; id_wr_idx = 3'd7;
        issue("reset", 0, 0, 0, 0, 1, 16'h0, 16'h0, 3'd0, 4'b0000, 3'd0);

        // plain capture
        idle(); id_valid = 1; id_rs_idx = 1; id_rs_used = 1; id_rs_val = 16'h1111;
        id_rt_idx = 4; id_rt_used = 1; id_rt_val = 16'h2222; id_op = 3'd3;
        id_inv_a = 1; id_cin = 1; id_wr_en = 1; id_wr_idx = 2;
        issue("capture", 0, 1, 1, 0, 1, 16'h1111, 16'h2222, 3'd3, 4'b1010, 3'd2);

        // EX/MEM and MEM/WB both write R3
        dec_rs3(); exm_wr_en = 1; exm_wr_idx = 3; exm_result = 16'hBEEF;
        mwb_wr_en = 1; mwb_wr_idx = 3; mwb_result = 16'h1234;
`ifdef IDEX_FWD_EN
        issue("dbl_fwd", 0, 1, 1, 0, 1, 16'hBEEF, 16'h5555, 3'd1, 4'b0000, 3'd6);
`else
        issue("dbl_fwd", 1, 0, 0, 0, 0, 16'h0, 16'h0, 3'd0, 4'b0000, 3'd0);
`endif

        // only MEM/WB writes R3; EX/MEM has matching index but wr_en=0
        dec_rs3(); exm_wr_en = 0; exm_wr_idx = 3; exm_result = 16'hDEAD;
        mwb_wr_en = 1; mwb_wr_idx = 3; mwb_result = 16'h1234;
`ifdef IDEX_FWD_EN
        issue("mwb_fwd", 0, 1, 1, 0, 1, 16'h1234, 16'h5555, 3'd1, 4'b0000, 3'd6);
`else
        issue("mwb_fwd", 1, 0, 0, 0, 0, 16'h0, 16'h0, 3'd0, 4'b0000, 3'd0);
`endif

        // index matches with wr_en=0 never forward or stall
        dec_rs3(); exm_wr_idx = 3; exm_result = 16'hDEAD; mwb_wr_idx = 3; mwb_result = 16'h1234;
        issue("no_wren", 0, 1, 1, 0, 1, 16'h0001, 16'h5555, 3'd1, 4'b0000, 3'd6);

        // immediate path: EX/MEM writing rt index is ignored on B
        idle(); id_valid = 1; id_rs_idx = 1; id_rs_used = 1; id_rs_val = 16'hAAAA;
        id_rt_idx = 5; id_rt_used = 1; id_rt_val = 16'h7777; id_use_imm = 1; id_imm = 16'hFFF0;
        id_op = 3'd2; id_inv_b = 1; id_sign = 1; id_wr_en = 1; id_wr_idx = 7;
        exm_wr_en = 1; exm_wr_idx = 5; exm_result = 16'hCAFE;
        issue("imm", 0, 1, 1, 0, 1, 16'hAAAA, 16'hFFF0, 3'd2, 4'b0101, 3'd7);

        // load to R5 enters EX
        idle(); id_valid = 1; id_rs_idx = 1; id_rs_used = 1; id_rs_val = 16'h0100;
        id_use_imm = 1; id_imm = 16'h0004; id_wr_en = 1; id_wr_idx = 5; id_is_load = 1;
        issue("load", 0, 1, 1, 1, 1, 16'h0100, 16'h0004, 3'd0, 4'b0000, 3'd5);

        // consumer of R5 right behind the load
        dec_use_r5();
        issue("load_use", 1, 0, 0, 0, 0, 16'h0, 16'h0, 3'd0, 4'b0000, 3'd0);

        // load now in MEM/WB
        dec_use_r5(); mwb_wr_en = 1; mwb_wr_idx = 5; mwb_result = 16'h5A5A;
`ifdef IDEX_FWD_EN
        issue("after_lu", 0, 1, 1, 0, 1, 16'h0010, 16'h5A5A, 3'd0, 4'b0000, 3'd3);
`else
        issue("after_lu", 1, 0, 0, 0, 0, 16'h0, 16'h0, 3'd0, 4'b0000, 3'd0);
        dec_use_r5(); id_rt_val = 16'h5A5A;
        issue("after_wb", 0, 1, 1, 0, 1, 16'h0010, 16'h5A5A, 3'd0, 4'b0000, 3'd3);
`endif

        // downstream hold for 3 cycles with changing decode inputs
        for (int i = 0; i < 3; i++) begin
            idle(); stall_in = 1; id_valid = 1; id_rs_idx = 4; id_rs_used = 1;
            id_rs_val = 16'h0100 + 16'(i); id_op = 3'(i + 4); id_wr_en = 1; id_wr_idx = 3'(i);
            issue("hold", 1, 1, 1, 0, 1, 16'h0010, 16'h5A5A, 3'd0, 4'b0000, 3'd3);
        end

        idle(); id_valid = 1; id_rs_idx = 4; id_rs_used = 1; id_rs_val = 16'h4444;
        id_rt_val = 16'h0042; id_op = 3'd5; id_cin = 1; id_wr_idx = 1;
        issue("release", 0, 1, 0, 0, 1, 16'h4444, 16'h0042, 3'd5, 4'b0010, 3'd1);

        // load to R2 into EX, then flush with stall_in and load-use together
        idle(); id_valid = 1; id_rs_idx = 4; id_rs_used = 1; id_rs_val = 16'h0001;
        id_use_imm = 1; id_imm = 16'h0008; id_wr_en = 1; id_wr_idx = 2; id_is_load = 1;
        issue("load2", 0, 1, 1, 1, 1, 16'h0001, 16'h0008, 3'd0, 4'b0000, 3'd2);

        idle(); flush = 1; stall_in = 1; id_valid = 1; id_rs_idx = 2; id_rs_used = 1;
        id_wr_en = 1; id_wr_idx = 4;
        issue("flush", 0, 0, 0, 0, 0, 16'h0, 16'h0, 3'd0, 4'b0000, 3'd0);

        idle();
        issue("invalid", 0, 0, 0, 0, 0, 16'h0, 16'h0, 3'd0, 4'b0000, 3'd0);

        // valid capture, then reset with flush asserted
        idle(); id_valid = 1; id_rs_val = 16'h0F0F; id_op = 3'd6; id_sign = 1;
        id_wr_en = 1; id_wr_idx = 4;
        issue("cap2", 0, 1, 1, 0, 1, 16'h0F0F, 16'h0000, 3'd6, 4'b0001, 3'd4);

        idle(); rst = 1; flush = 1; id_valid = 1; id_rs_val = 16'hFFFF; id_wr_en = 1;
        issue("reset2", 0, 0, 0, 0, 1, 16'h0, 16'h0, 3'd0, 4'b0000, 3'd0);

        idle();
        repeat (3) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
